// File: rtl/instr_encode_pkg.sv
// Shared widths, field positions, FSM states and helpers for the instruction encoder.
package instr_encode_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int BYTE_SIZE  = 8;
    localparam int NIB_SIZE   = 4;
    localparam int FIFO_DEPTH = 2;

    // Field positions inside an instruction word: {opcode, reg1, reg2, reg3}
    localparam int OP_MSB  = WORD_SIZE - 1;
    localparam int OP_LSB  = WORD_SIZE - NIB_SIZE;
    localparam int R1_MSB  = OP_LSB - 1;
    localparam int R1_LSB  = OP_LSB - NIB_SIZE;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One pending write: destination address plus encoded word
    typedef struct packed {
        word_t addr;
        word_t word;
    } wr_entry_t;

    // ALU ops live in the lower half of the opcode space
    function automatic logic is_alu_space(input logic [NIB_SIZE-1:0] op);
        return !op[NIB_SIZE-1];
    endfunction

endpackage

// File: rtl/instr_encode_if.sv
// Field stream from the host plus the instruction-memory write port.
interface instr_encode_if;
    import instr_encode_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_isaluop;
    logic [2:0]           in_aluop;
    logic [NIB_SIZE-1:0]  in_opcode;
    logic [NIB_SIZE-1:0]  in_reg1;
    logic [NIB_SIZE-1:0]  in_reg2;
    logic [NIB_SIZE-1:0]  in_reg3;
    logic                 in_usebig;
    logic [BYTE_SIZE-1:0] in_bigval;

    logic                 mem_we;
    word_t                mem_addr;
    word_t                mem_wdata;
    logic                 mem_ready;

    // Encoder side
    modport slave (
        input  in_valid, in_isaluop, in_aluop, in_opcode,
               in_reg1, in_reg2, in_reg3, in_usebig, in_bigval,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_ready
    );

    // Host / memory side
    modport master (
        output in_valid, in_isaluop, in_aluop, in_opcode,
               in_reg1, in_reg2, in_reg3, in_usebig, in_bigval,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_ready
    );

endinterface

// File: rtl/instr_encode_word_fifo.sv
// Small synchronous FIFO holding {addr, word} entries awaiting the memory write port.
module word_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on the pointers distinguishes full from empty
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; reset discards any queued entries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/instr_encode.sv
// Packs decoded instruction fields into words and streams them into instruction memory.
module instr_encode
    import instr_encode_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  word_t          start_addr,
    input  logic           finish,
    instr_encode_if.slave  bus,
    output logic           busy,
    output logic           done,
    output word_t          wr_count,
    output logic           bad_op,
    output logic           overflow
);

    state_t               state;
    word_t                push_addr;
    logic                 addr_exh;
    logic                 fifo_full;
    logic                 fifo_empty;
    wr_entry_t            head;
    wr_entry_t            push_entry;
    logic [NIB_SIZE-1:0]  op;
    logic [BYTE_SIZE-1:0] lo;
    logic                 accept;
    logic                 reject;
    logic                 push;
    logic                 write_done;
    logic                 last_write;

    // Ready is a function of registered state only, so a pop in the same
    // cycle never frees a slot for a push.
    assign bus.in_ready = (state == ST_RUN) && !fifo_full && !addr_exh;
    assign accept       = bus.in_valid && bus.in_ready;

    assign op  = bus.in_isaluop ? {1'b0, bus.in_aluop} : bus.in_opcode;
    assign lo  = bus.in_usebig ? bus.in_bigval : {bus.in_reg2, bus.in_reg3};

    // Non-ALU opcodes in the ALU half are consumed but never written
    assign reject = accept && !bus.in_isaluop && is_alu_space(bus.in_opcode);
    assign push   = accept && !reject;

    // Address is bound at push time so the write port just replays it
    assign push_entry = '{addr: push_addr, word: {op, bus.in_reg1, lo}};

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wr_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (push_entry),
        .pop     (write_done),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.mem_we    = !fifo_empty;
    assign bus.mem_addr  = fifo_empty ? '0 : head.addr;
    assign bus.mem_wdata = fifo_empty ? '0 : head.word;

    assign write_done = !fifo_empty && bus.mem_ready;
    assign last_write = write_done && (head.addr == '1);

    // Session FSM with address counter, completion count and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            push_addr <= '0;
            addr_exh  <= 1'b0;
            wr_count  <= '0;
            bad_op    <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) begin
                push_addr <= push_addr + 1'b1;
                if (push_addr == '1) addr_exh <= 1'b1;
            end
            if (reject)     bad_op   <= 1'b1;
            if (write_done) wr_count <= wr_count + 1'b1;
            if (last_write) overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        push_addr <= start_addr;
                        addr_exh  <= 1'b0;
                        wr_count  <= '0;
                        bad_op    <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A word accepted alongside finish is still pushed above
                    if (finish || last_write) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Empty FIFO implies no write is outstanding
                    if (fifo_empty) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Scoreboard bench for instr_encode: driver predicts writes, monitor checks the memory port.
module tb_instr_encode;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic [15:0] start_addr = '0;
    logic        busy, done, bad_op, overflow;
    logic [15:0] wr_count;

    instr_encode_if bus();

    instr_encode dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .finish     (finish),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count),
        .bad_op     (bad_op),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] exp_q[$];
    logic [15:0] m_addr = '0;
    bit          m_exh = 0;
    bit          m_bad = 0;
    int          m_good = 0;

    // Memory-side ready generator
    bit rand_ready  = 0;
    bit fixed_ready = 0;
    always @(posedge clk) begin
        #2;
        bus.mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end

    // Monitor: pops and compares every completed write, checks stall stability and done
    int          done_cnt = 0;
    bit          prev_done = 0;
    bit          stall_v = 0;
    logic [31:0] held;
    logic [31:0] e;
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_v   = 0;
            prev_done = 0;
        end else begin
            if (stall_v) begin
                check("stall_we", {31'd0, bus.mem_we}, 32'd1);
                check("stall_hold", {bus.mem_addr, bus.mem_wdata}, held);
            end
            stall_v = 0;
            if (bus.mem_we === 1'b1) begin
                if (bus.mem_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        nchecks++;
                        nfail++;
                        $display("FAIL unexpected_write: got %h expected none",
                                 {bus.mem_addr, bus.mem_wdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", {16'd0, bus.mem_addr}, {16'd0, e[31:16]});
                        check("wr_data", {16'd0, bus.mem_wdata}, {16'd0, e[15:0]});
                    end
                end else begin
                    stall_v = 1;
                    held    = {bus.mem_addr, bus.mem_wdata};
                end
            end
            if (done) begin
                done_cnt++;
                check("done_single", {31'd0, prev_done}, 32'd0);
            end
            prev_done = done;
        end
    end

    // Model of one accepted field set, straight from the encoding rules
    task automatic model_accept();
        int op, lo, word;
        if (!bus.in_isaluop && bus.in_opcode < 8) begin
            m_bad = 1;
        end else begin
            check("no_accept_exhausted", {31'd0, m_exh}, 32'd0);
            op   = bus.in_isaluop ? int'(bus.in_aluop) : int'(bus.in_opcode);
            lo   = bus.in_usebig ? int'(bus.in_bigval) : int'(bus.in_reg2) * 16 + int'(bus.in_reg3);
            word = op * 4096 + int'(bus.in_reg1) * 256 + lo;
            exp_q.push_back({m_addr, word[15:0]});
            m_good++;
            if (m_addr == 16'hFFFF) m_exh = 1;
            m_addr = m_addr + 16'd1;
        end
    endtask

    task automatic drive_word(input bit isalu, input logic [2:0] aluop, input logic [3:0] opc,
                              input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
                              input bit ub, input logic [7:0] big);
        bus.in_isaluop = isalu;
        bus.in_aluop   = aluop;
        bus.in_opcode  = opc;
        bus.in_reg1    = r1;
        bus.in_reg2    = r2;
        bus.in_reg3    = r3;
        bus.in_usebig  = ub;
        bus.in_bigval  = big;
        bus.in_valid   = 1'b1;
    endtask

    task automatic drive_random();
        drive_word(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    endtask

    // One cycle: decide acceptance mid-cycle, then move past the edge
    task automatic step(output bit acc);
        @(negedge clk);
        acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
        if (acc) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int budget, output bit acc);
        acc = 0;
        for (int i = 0; i < budget && !acc; i++) step(acc);
    endtask

    task automatic start_session(input logic [15:0] a);
        start_addr = a;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        m_addr = a;
        m_exh  = 0;
        m_bad  = 0;
        m_good = 0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("wr_count_cleared", {16'd0, wr_count}, 32'd0);
        check("flags_cleared", {30'd0, bad_op, overflow}, 32'd0);
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 300 && done_cnt == prev; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("done_seen", {31'd0, done_cnt > prev}, 32'd1);
    endtask

    task automatic post_checks(input bit exp_ovf);
        check("wr_count", {16'd0, wr_count}, m_good);
        check("bad_op", {31'd0, bad_op}, {31'd0, m_bad});
        check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {16'd0, bus.mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
        check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_wr_count"}, {16'd0, wr_count}, 32'd0);
        check({tag, "_flags"}, {30'd0, bad_op, overflow}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, any;
        int pd, accepts;
        logic [3:0] bw_r1 [3];

        bus.in_valid = 1'b0;
        drive_word(0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;

        // Reset values
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        fixed_ready = 1;
        @(posedge clk);
        #1;

        // ALU encode with one-cycle accept-to-write latency
        pd = done_cnt;
        start_session(16'h0010);
        drive_word(1, 3'd3, 4'd0, 4'd1, 4'd2, 4'd4, 0, 8'h00);
        send_word(10, acc);
        check("alu_accept", {31'd0, acc}, 32'd1);
        check("alu_we", {31'd0, bus.mem_we}, 32'd1);
        check("alu_addr", {16'd0, bus.mem_addr}, 32'h0010);
        check("alu_data", {16'd0, bus.mem_wdata}, 32'h3124);
        bus.in_valid = 1'b0;
        pulse_finish();
        wait_done(pd);
        post_checks(0);

        // finish outside RUN is ignored
        pd = done_cnt;
        pulse_finish();
        repeat (3) @(posedge clk);
        #1;
        check("finish_idle_ignored", {busy, 31'(done_cnt - pd)}, 32'd0);

        // Immediate encode, finish in the same cycle as the word
        pd = done_cnt;
        start_session(16'h0020);
        drive_word(0, 3'd0, 4'hA, 4'd7, 4'd1, 4'd1, 1, 8'h5C);
        finish = 1'b1;
        step(acc);
        finish = 1'b0;
        bus.in_valid = 1'b0;
        check("imm_accept", {31'd0, acc}, 32'd1);
        check("imm_data", {16'd0, bus.mem_wdata}, 32'hA75C);
        check("imm_addr", {16'd0, bus.mem_addr}, 32'h0020);
        wait_done(pd);
        post_checks(0);

        // Bad op is consumed, not written, and does not advance the address
        pd = done_cnt;
        start_session(16'h0040);
        drive_word(0, 3'd0, 4'h2, 4'd3, 4'd4, 4'd5, 0, 8'h00);
        send_word(10, acc);
        check("bad_accept", {31'd0, acc}, 32'd1);
        check("bad_no_write", {31'd0, bus.mem_we}, 32'd0);
        drive_word(0, 3'd0, 4'h9, 4'd1, 4'd2, 4'd3, 0, 8'h00);
        send_word(10, acc);
        check("good_addr", {16'd0, bus.mem_addr}, 32'h0040);
        bus.in_valid = 1'b0;
        pulse_finish();
        wait_done(pd);
        post_checks(0);

        // Backpressure: two accepts fill the buffer while memory stalls
        fixed_ready = 0;
        pd = done_cnt;
        start_session(16'h0100);
        bw_r1[0] = 4'd1; bw_r1[1] = 4'd2; bw_r1[2] = 4'd3;
        accepts = 0;
        drive_word(1, 3'd5, 4'd0, bw_r1[0], 4'd6, 4'd7, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(acc);
            if (acc) begin
                accepts++;
                if (accepts < 3) drive_word(1, 3'd5, 4'd0, bw_r1[accepts], 4'd6, 4'd7, 0, 8'h00);
            end
        end
        check("bp_accepts", accepts, 32'd2);
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        fixed_ready = 1;
        send_word(20, acc);
        check("bp_third_accept", {31'd0, acc}, 32'd1);
        bus.in_valid = 1'b0;
        pulse_finish();
        wait_done(pd);
        post_checks(0);

        // Address exhaustion at the top of the space
        pd = done_cnt;
        start_session(16'hFFFF);
        drive_word(0, 3'd0, 4'hC, 4'd1, 4'd2, 4'd3, 0, 8'h00);
        send_word(10, acc);
        check("exh_first_accept", {31'd0, acc}, 32'd1);
        drive_word(0, 3'd0, 4'hD, 4'd4, 4'd5, 4'd6, 0, 8'h00);
        any = 0;
        for (int i = 0; i < 8; i++) begin
            step(acc);
            any |= acc;
        end
        check("exh_second_refused", {31'd0, any}, 32'd0);
        bus.in_valid = 1'b0;
        wait_done(pd);
        post_checks(1);

        // Randomized sessions with random memory backpressure
        rand_ready = 1;
        for (int s = 0; s < 3; s++) begin
            pd = done_cnt;
            start_session(16'($urandom_range(0, 16'hF000)));
            for (int i = 0; i < 25; i++) begin
                drive_random();
                if (s == 1 && i == 10) begin
                    start_addr = 16'($urandom_range(0, 16'hFFFF));
                    start = 1'b1;
                end
                send_word(100, acc);
                start = 1'b0;
                check("rand_accept", {31'd0, acc}, 32'd1);
                if ($urandom_range(0, 4) == 0) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b0;
            pulse_finish();
            wait_done(pd);
            post_checks(0);
        end
        rand_ready = 0;

        // Reset during a stalled drain
        fixed_ready = 0;
        @(posedge clk);
        #1;
        start_session(16'h0200);
        drive_word(1, 3'd1, 4'd0, 4'd2, 4'd3, 4'd4, 0, 8'h00);
        send_word(10, acc);
        bus.in_valid = 1'b0;
        pulse_finish();
        repeat (3) @(posedge clk);
        #1;
        check("drain_stalled", {30'd0, busy, bus.mem_we}, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        fixed_ready = 1;
        @(posedge clk);
        #1;
        pd = done_cnt;
        start_session(16'h0300);
        drive_word(0, 3'd0, 4'hF, 4'd8, 4'd9, 4'd10, 0, 8'h00);
        send_word(10, acc);
        bus.in_valid = 1'b0;
        pulse_finish();
        wait_done(pd);
        post_checks(0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
